// File: rtl/fetch.sv
// Instruction-fetch stage: reads one word from instruction BRAM per request and
// hands instr/pc to decode with a one-cycle decode_en pulse. Owns next-PC.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for fetch_en_i; BRAM address holds
// S_WAIT  | BRAM read in flight, cnt_q counts down the latency
// S_ISSUE | instr_o/pc_o valid, decode_en_o high for one cycle
module fetch #(
    parameter int                  PC_WIDTH     = 19,
    parameter int                  IMEM_LATENCY = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                fetch_en_i,
    input  logic                flush_i,
    input  logic                pc_we_i,
    input  logic [PC_WIDTH-1:0] pc_wdata_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]         imem_rdata_i,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                decode_en_o,
    output logic                busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [2:0] LAT     = 3'(IMEM_LATENCY);

    logic [1:0]          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] npc_q, npc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                dec_q, dec_d;
    logic [PC_WIDTH-1:0] eff_pc;

    assign eff_pc = pc_we_i ? pc_wdata_i : npc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        npc_d   = npc_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        dec_d   = 1'b0;

        // A redirect always lands in npc; an accepted fetch overrides it below.
        if (pc_we_i) begin
            npc_d = pc_wdata_i;
        end

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_en_i) begin
                        addr_d  = eff_pc;
                        pc_d    = eff_pc;
                        npc_d   = eff_pc + 1'b1;
                        cnt_d   = LAT;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        instr_d = imem_rdata_i;
                        dec_d   = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            npc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            pc_q    <= '0;
            instr_q <= 32'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            npc_q   <= npc_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dec_q   <= dec_d;
        end
    end

    assign imem_addr_o = addr_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign decode_en_o = dec_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
